// File: rtl/jtag_tap_cfg_multi_if.sv
// External scan channel between the TAP and an off-block scan chain.
// The master side (TAP) provides selects and state decodes; the slave side returns serial data.
interface jtag_tap_cfg_multi_if;
    logic ext_sel;
    logic ext_capture_dr;
    logic ext_shift_dr;
    logic ext_update_dr;
    logic ext_scan_in;
    logic ext_scan_out;

    modport master (
        output ext_sel, ext_capture_dr, ext_shift_dr, ext_update_dr, ext_scan_in,
        input  ext_scan_out
    );

    modport slave (
        input  ext_sel, ext_capture_dr, ext_shift_dr, ext_update_dr, ext_scan_in,
        output ext_scan_out
    );
endinterface

// File: rtl/jtag_tap_cfg_multi.sv
// IEEE 1149.1 TAP with IDCODE, BYPASS, NUM_CFG capture/update config registers and one external scan channel.
// state group            | meaning
// TLR / RTI              | test-logic-reset (IR=IDCODE) / idle
// SEL/CAP/SHIFT/EXIT1/   | standard DR column (capture, shift, pause, update)
//   PAUSE/EXIT2/UPD _DR  |
// same names with _IR    | standard IR column
module jtag_tap_cfg_multi #(
    parameter int                 IR_LEN      = 5,
    parameter int                 NUM_CFG     = 2,
    parameter int                 CFG_W       = 9,
    parameter logic [CFG_W-1:0]   CFG_RST     = '0,
    parameter logic [31:0]        IDCODE_VAL  = 32'h10102001,
    parameter int                 CFG_IR_BASE = 8,
    parameter int                 EXT_IR      = 4,
    parameter int                 SYNC_STAGES = 2
) (
    input  logic                       tck_i,
    input  logic                       trst_ni,
    input  logic                       tms_i,
    input  logic                       td_i,
    output logic                       td_o,
    output logic                       td_oe_o,
    input  logic [NUM_CFG*CFG_W-1:0]   soc_status_i,
    output logic [NUM_CFG*CFG_W-1:0]   cfg_o,
    output logic [NUM_CFG-1:0]         cfg_upd_o,
    jtag_tap_cfg_multi_if.master       ext
);

    typedef enum logic [3:0] {
        TLR, RTI,
        SEL_DR, CAP_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPD_DR,
        SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPD_IR
    } tap_state_t;

    tap_state_t state, state_nxt;

    logic [IR_LEN-1:0]         ir, ir_sr;
    logic                      bypass_sr;
    logic [31:0]               idcode_sr;
    logic [CFG_W-1:0]          cfg_sr;
    logic [CFG_W-1:0]          cap_word;
    logic [NUM_CFG*CFG_W-1:0]  sync_q [SYNC_STAGES];

    logic                      sel_bypass, sel_idcode, sel_cfg, sel_ext;
    logic [2:0]                cfg_idx;
    logic                      dr_lsb;

    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) state <= TLR;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            TLR:      state_nxt = tms_i ? TLR      : RTI;
            RTI:      state_nxt = tms_i ? SEL_DR   : RTI;
            SEL_DR:   state_nxt = tms_i ? SEL_IR   : CAP_DR;
            CAP_DR:   state_nxt = tms_i ? EXIT1_DR : SHIFT_DR;
            SHIFT_DR: state_nxt = tms_i ? EXIT1_DR : SHIFT_DR;
            EXIT1_DR: state_nxt = tms_i ? UPD_DR   : PAUSE_DR;
            PAUSE_DR: state_nxt = tms_i ? EXIT2_DR : PAUSE_DR;
            EXIT2_DR: state_nxt = tms_i ? UPD_DR   : SHIFT_DR;
            UPD_DR:   state_nxt = tms_i ? SEL_DR   : RTI;
            SEL_IR:   state_nxt = tms_i ? TLR      : CAP_IR;
            CAP_IR:   state_nxt = tms_i ? EXIT1_IR : SHIFT_IR;
            SHIFT_IR: state_nxt = tms_i ? EXIT1_IR : SHIFT_IR;
            EXIT1_IR: state_nxt = tms_i ? UPD_IR   : PAUSE_IR;
            PAUSE_IR: state_nxt = tms_i ? EXIT2_IR : PAUSE_IR;
            EXIT2_IR: state_nxt = tms_i ? UPD_IR   : SHIFT_IR;
            UPD_IR:   state_nxt = tms_i ? SEL_DR   : RTI;
            default:  state_nxt = TLR;
        endcase
    end

    // Opcode decode in priority order; anything unrecognised falls back to BYPASS.
    always_comb begin
        sel_bypass = 1'b0;
        sel_idcode = 1'b0;
        sel_cfg    = 1'b0;
        sel_ext    = 1'b0;
        cfg_idx    = '0;
        if (ir == {IR_LEN{1'b1}}) begin
            sel_bypass = 1'b1;
        end else if (ir == IR_LEN'(1)) begin
            sel_idcode = 1'b1;
        end else begin
            for (int k = 0; k < NUM_CFG; k++) begin
                if (ir == IR_LEN'(CFG_IR_BASE + k)) begin
                    sel_cfg = 1'b1;
                    cfg_idx = 3'(k);
                end
            end
            if (!sel_cfg) begin
                if (ir == IR_LEN'(EXT_IR)) sel_ext = 1'b1;
                else                       sel_bypass = 1'b1;
            end
        end
    end

    always_comb begin
        cap_word = '0;
        for (int k = 0; k < NUM_CFG; k++) begin
            if (cfg_idx == 3'(k)) cap_word = sync_q[SYNC_STAGES-1][k*CFG_W +: CFG_W];
        end
    end

    always_comb begin
        ext.ext_sel        = sel_ext;
        ext.ext_capture_dr = sel_ext && (state == CAP_DR);
        ext.ext_shift_dr   = sel_ext && (state == SHIFT_DR);
        ext.ext_update_dr  = sel_ext && (state == UPD_DR);
        ext.ext_scan_in    = td_i;
    end

    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= soc_status_i;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            ir        <= IR_LEN'(1);
            ir_sr     <= '0;
            bypass_sr <= 1'b0;
            idcode_sr <= '0;
            cfg_sr    <= '0;
            cfg_o     <= {NUM_CFG{CFG_RST}};
            cfg_upd_o <= '0;
        end else begin
            cfg_upd_o <= '0;
            case (state)
                TLR:      ir <= IR_LEN'(1);
                CAP_IR:   ir_sr <= IR_LEN'(1);
                SHIFT_IR: ir_sr <= {td_i, ir_sr[IR_LEN-1:1]};
                UPD_IR:   ir <= ir_sr;
                CAP_DR: begin
                    if (sel_bypass) bypass_sr <= 1'b0;
                    if (sel_idcode) idcode_sr <= IDCODE_VAL;
                    if (sel_cfg)    cfg_sr    <= cap_word;
                end
                SHIFT_DR: begin
                    if (sel_bypass) bypass_sr <= td_i;
                    if (sel_idcode) idcode_sr <= {td_i, idcode_sr[31:1]};
                    if (sel_cfg)    cfg_sr    <= {td_i, cfg_sr[CFG_W-1:1]};
                end
                UPD_DR: begin
                    for (int k = 0; k < NUM_CFG; k++) begin
                        if (sel_cfg && cfg_idx == 3'(k)) begin
                            cfg_o[k*CFG_W +: CFG_W] <= cfg_sr;
                            cfg_upd_o[k]            <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        if (sel_ext)         dr_lsb = ext.ext_scan_out;
        else if (sel_idcode) dr_lsb = idcode_sr[0];
        else if (sel_cfg)    dr_lsb = cfg_sr[0];
        else                 dr_lsb = bypass_sr;
    end

    // TDO launches on the falling edge so the host samples a stable bit on the next rising edge.
    always_ff @(negedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            td_o    <= 1'b0;
            td_oe_o <= 1'b0;
        end else if (state == SHIFT_IR) begin
            td_o    <= ir_sr[0];
            td_oe_o <= 1'b1;
        end else if (state == SHIFT_DR) begin
            td_o    <= dr_lsb;
            td_oe_o <= 1'b1;
        end else begin
            td_oe_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_jtag_tap_cfg_multi.sv
// Directed bench for jtag_tap_cfg_multi: IDCODE, BYPASS, config write/capture, external channel and resets.
module tb_jtag_tap_cfg_multi;
    localparam logic [31:0] IDCODE = 32'h10102001;

    logic        tck = 1'b0;
    logic        trst_n = 1'b0;
    logic        tms = 1'b0;
    logic        tdi = 1'b0;
    logic        tdo, tdo_oe;
    logic [17:0] soc_status = '0;
    logic [17:0] cfg;
    logic [1:0]  cfg_upd;
    logic [2:0]  chain;

    int n_checks = 0;
    int n_fail   = 0;

    logic s_tdo, s_oe, s_esh, s_ecap, s_eupd;
    int   esh_cnt, esh_bad, ecap_cnt, eupd_cnt, oe_bad;

    jtag_tap_cfg_multi_if ext_bus();

    jtag_tap_cfg_multi dut (
        .tck_i        (tck),
        .trst_ni      (trst_n),
        .tms_i        (tms),
        .td_i         (tdi),
        .td_o         (tdo),
        .td_oe_o      (tdo_oe),
        .soc_status_i (soc_status),
        .cfg_o        (cfg),
        .cfg_upd_o    (cfg_upd),
        .ext          (ext_bus)
    );

    always #5 tck = ~tck;

    // Three-flop external chain looped from ext_scan_in back to ext_scan_out.
    always @(posedge tck or negedge trst_n) begin
        if (!trst_n) chain <= '0;
        else         chain <= {chain[1:0], ext_bus.ext_scan_in};
    end
    assign ext_bus.ext_scan_out = chain[2];

    task automatic step(input logic t, input logic d);
        tms = t;
        tdi = d;
        @(negedge tck); #1;
        s_tdo  = tdo;
        s_oe   = tdo_oe;
        s_esh  = ext_bus.ext_shift_dr;
        s_ecap = ext_bus.ext_capture_dr;
        s_eupd = ext_bus.ext_update_dr;
        @(posedge tck); #1;
    endtask

    task automatic observe(input bit in_shift);
        if (s_oe !== in_shift) oe_bad++;
        if (s_esh === 1'b1) esh_cnt++;
        if (s_esh !== (in_shift && ext_bus.ext_sel)) esh_bad++;
        if (s_ecap === 1'b1) ecap_cnt++;
        if (s_eupd === 1'b1) eupd_cnt++;
    endtask

    task automatic tms_reset();
        repeat (5) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    task automatic load_ir(input logic [4:0] v, output logic [4:0] cap);
        cap = '0;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(i == 4, v[i]);
            cap[i] = s_tdo;
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    task automatic scan_dr(input int n, input logic [31:0] din, output logic [31:0] dout);
        dout = '0;
        esh_cnt = 0; esh_bad = 0; ecap_cnt = 0; eupd_cnt = 0; oe_bad = 0;
        step(1'b1, 1'b0); observe(1'b0);
        step(1'b0, 1'b0); observe(1'b0);
        step(1'b0, 1'b0); observe(1'b0);
        for (int i = 0; i < n; i++) begin
            step(i == n - 1, din[i]);
            observe(1'b1);
            dout[i] = s_tdo;
        end
        step(1'b1, 1'b0); observe(1'b0);
        step(1'b0, 1'b0); observe(1'b0);
    endtask

    task automatic test_reset();
        trst_n = 1'b0;
        repeat (2) @(posedge tck);
        #1;
        n_checks++; if (cfg !== 18'h0)   begin n_fail++; $display("FAIL reset_cfg got=%h exp=%h", cfg, 18'h0); end
        n_checks++; if (cfg_upd !== 2'b0) begin n_fail++; $display("FAIL reset_upd got=%b exp=00", cfg_upd); end
        n_checks++; if (tdo_oe !== 1'b0) begin n_fail++; $display("FAIL reset_oe got=%b exp=0", tdo_oe); end
        n_checks++; if (tdo !== 1'b0)    begin n_fail++; $display("FAIL reset_tdo got=%b exp=0", tdo); end
        n_checks++; if (ext_bus.ext_sel !== 1'b0) begin n_fail++; $display("FAIL reset_ext_sel got=%b exp=0", ext_bus.ext_sel); end
        trst_n = 1'b1;
    endtask

    task automatic test_idcode();
        logic [31:0] d;
        tms_reset();
        scan_dr(32, 32'h0, d);
        n_checks++; if (d !== IDCODE) begin n_fail++; $display("FAIL idcode got=%h exp=%h", d, IDCODE); end
        n_checks++; if (oe_bad !== 0) begin n_fail++; $display("FAIL idcode_oe bad_cycles=%0d exp=0", oe_bad); end
        n_checks++; if (esh_cnt !== 0) begin n_fail++; $display("FAIL idcode_ext_shift got=%0d exp=0", esh_cnt); end
        n_checks++; if (cfg_upd !== 2'b0) begin n_fail++; $display("FAIL idcode_upd got=%b exp=00", cfg_upd); end
    endtask

    task automatic test_bypass();
        logic [4:0]  c;
        logic [31:0] d;
        load_ir(5'h1F, c);
        n_checks++; if (c !== 5'b00001) begin n_fail++; $display("FAIL ir_capture got=%b exp=00001", c); end
        scan_dr(8, 32'hA5, d);
        n_checks++; if (d[7:0] !== 8'h4A) begin n_fail++; $display("FAIL bypass got=%h exp=4a", d[7:0]); end
    endtask

    task automatic test_cfg_write();
        logic [4:0]  c;
        logic [31:0] d;
        load_ir(5'd8, c);
        scan_dr(9, 32'h1AB, d);
        n_checks++; if (d[8:0] !== 9'h000) begin n_fail++; $display("FAIL cfg0_capture got=%h exp=000", d[8:0]); end
        n_checks++; if (cfg !== {9'h000, 9'h1AB}) begin n_fail++; $display("FAIL cfg0_write got=%h exp=%h", cfg, {9'h000, 9'h1AB}); end
        n_checks++; if (cfg_upd !== 2'b01) begin n_fail++; $display("FAIL cfg0_upd got=%b exp=01", cfg_upd); end
        step(1'b0, 1'b0);
        n_checks++; if (cfg_upd !== 2'b00) begin n_fail++; $display("FAIL cfg0_upd_width got=%b exp=00", cfg_upd); end
    endtask

    task automatic test_status_capture();
        logic [4:0]  c;
        logic [31:0] d;
        soc_status = {9'h0F3, 9'h055};
        repeat (3) step(1'b0, 1'b0);
        load_ir(5'd9, c);
        scan_dr(9, 32'h155, d);
        n_checks++; if (d[8:0] !== 9'h0F3) begin n_fail++; $display("FAIL cfg1_capture got=%h exp=0f3", d[8:0]); end
        n_checks++; if (cfg !== {9'h155, 9'h1AB}) begin n_fail++; $display("FAIL cfg1_write got=%h exp=%h", cfg, {9'h155, 9'h1AB}); end
        n_checks++; if (cfg_upd !== 2'b10) begin n_fail++; $display("FAIL cfg1_upd got=%b exp=10", cfg_upd); end
    endtask

    task automatic test_zero_shift();
        logic [4:0] c;
        load_ir(5'd8, c);
        n_checks++; if (cfg !== {9'h155, 9'h1AB}) begin n_fail++; $display("FAIL ir_change_cfg got=%h exp=%h", cfg, {9'h155, 9'h1AB}); end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        n_checks++; if (cfg !== {9'h155, 9'h055}) begin n_fail++; $display("FAIL zero_shift_cfg got=%h exp=%h", cfg, {9'h155, 9'h055}); end
        n_checks++; if (cfg_upd !== 2'b01) begin n_fail++; $display("FAIL zero_shift_upd got=%b exp=01", cfg_upd); end
    endtask

    task automatic test_tlr_keeps_cfg();
        logic [31:0] d;
        tms_reset();
        n_checks++; if (cfg !== {9'h155, 9'h055}) begin n_fail++; $display("FAIL tlr_cfg got=%h exp=%h", cfg, {9'h155, 9'h055}); end
        scan_dr(32, 32'h0, d);
        n_checks++; if (d !== IDCODE) begin n_fail++; $display("FAIL tlr_idcode got=%h exp=%h", d, IDCODE); end
    endtask

    task automatic test_ext();
        logic [4:0]  c;
        logic [31:0] d;
        load_ir(5'd4, c);
        n_checks++; if (ext_bus.ext_sel !== 1'b1) begin n_fail++; $display("FAIL ext_sel got=%b exp=1", ext_bus.ext_sel); end
        scan_dr(8, 32'hA5, d);
        n_checks++; if (d[7:0] !== 8'h28) begin n_fail++; $display("FAIL ext_echo got=%h exp=28", d[7:0]); end
        n_checks++; if (esh_cnt !== 8) begin n_fail++; $display("FAIL ext_shift_cnt got=%0d exp=8", esh_cnt); end
        n_checks++; if (esh_bad !== 0) begin n_fail++; $display("FAIL ext_shift_window bad_cycles=%0d exp=0", esh_bad); end
        n_checks++; if (ecap_cnt !== 1) begin n_fail++; $display("FAIL ext_capture_cnt got=%0d exp=1", ecap_cnt); end
        n_checks++; if (eupd_cnt !== 1) begin n_fail++; $display("FAIL ext_update_cnt got=%0d exp=1", eupd_cnt); end
        n_checks++; if (cfg !== {9'h155, 9'h055}) begin n_fail++; $display("FAIL ext_cfg got=%h exp=%h", cfg, {9'h155, 9'h055}); end
    endtask

    task automatic test_reset_mid_shift();
        logic [4:0]  c;
        logic [31:0] d;
        load_ir(5'd8, c);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        repeat (4) step(1'b0, 1'b1);
        #2 trst_n = 1'b0;
        #1;
        n_checks++; if (cfg !== 18'h0) begin n_fail++; $display("FAIL midrst_cfg got=%h exp=%h", cfg, 18'h0); end
        n_checks++; if (tdo_oe !== 1'b0) begin n_fail++; $display("FAIL midrst_oe got=%b exp=0", tdo_oe); end
        n_checks++; if (cfg_upd !== 2'b00) begin n_fail++; $display("FAIL midrst_upd got=%b exp=00", cfg_upd); end
        @(posedge tck); #1;
        trst_n = 1'b1;
        step(1'b0, 1'b0);
        scan_dr(32, 32'h0, d);
        n_checks++; if (d !== IDCODE) begin n_fail++; $display("FAIL midrst_ir_idcode got=%h exp=%h", d, IDCODE); end
        n_checks++; if (cfg !== 18'h0) begin n_fail++; $display("FAIL midrst_cfg_after got=%h exp=%h", cfg, 18'h0); end
        n_checks++; if (cfg_upd !== 2'b00) begin n_fail++; $display("FAIL midrst_upd_after got=%b exp=00", cfg_upd); end
    endtask

    initial begin
        test_reset();
        test_idcode();
        test_bypass();
        test_cfg_write();
        test_status_capture();
        test_zero_shift();
        test_tlr_keeps_cfg();
        test_ext();
        test_reset_mid_shift();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/jtag_tap_cfg_multi.md
Name: jtag_tap_cfg_multi

Overview:
- Self-contained IEEE 1149.1 TAP with parametrised IR length, IDCODE, BYPASS, NUM_CFG configuration data registers of CFG_W bits each, and one external scan channel (e.g. debug AXI scan chain).
- Each config register captures a synchronised SoC status word and drives a held configuration output with a per-register update strobe.
- Sits at the chip JTAG pins; the next-generation replacement for the single fixed 9-bit confreg TAP wrapper.

Parameters:
- IR_LEN, 5, instruction register length (>=4).
- NUM_CFG, 2, number of config data registers (1..8).
- CFG_W, 9, width of each config register (2..32).
- CFG_RST, 0, reset value of every config output word (CFG_W bits).
- IDCODE_VAL, 32'h10102001, IDCODE content; bit0 must be 1.
- CFG_IR_BASE, 8, IR opcode of config reg 0; reg k uses CFG_IR_BASE+k.
- EXT_IR, 4, IR opcode selecting the external scan channel.
- SYNC_STAGES, 2, flops in the soc_status_i synchroniser (>=2).

Ports:
- tck_i  in  1  JTAG clock, sole clock.
- trst_ni  in  1  asynchronous active-low reset.
- tms_i  in  1  test mode select.
- td_i  in  1  test data in.
- td_o  out  1  test data out, registered on negedge tck_i.
- td_oe_o  out  1  td_o enable, high only in Shift-DR/Shift-IR, registered on negedge.
- soc_status_i  in  NUM_CFG*CFG_W  SoC status, async to tck; word k = bits [k*CFG_W +: CFG_W].
- cfg_o  out  NUM_CFG*CFG_W  held config words.
- cfg_upd_o  out  NUM_CFG  one-tck pulse when word k is updated.
- ext_sel_o  out  1  IR == EXT_IR.
- ext_capture_dr_o / ext_shift_dr_o / ext_update_dr_o  out  1 each  TAP state decodes, gated with ext_sel_o.
- ext_scan_in_o  out  1  td_i forwarded to the external chain.
- ext_scan_out_i  in  1  external chain serial output.

Behaviour:
- Clock and reset: one clock, tck_i; reset trst_ni is asynchronous and active-low. All flops clear on trst_ni low: FSM=Test-Logic-Reset, IR=IDCODE (1), cfg_o=CFG_RST replicated, cfg_upd_o=0, td_o=0, td_oe_o=0, synchroniser=0.
- FSM: standard 16-state TAP, transitions on posedge tck_i per tms_i. Five consecutive tms_i=1 from any state reach Test-Logic-Reset, which also loads IR=IDCODE.
- IR path:
  - Capture-IR loads shift reg with {0..0,01}.
  - Shift-IR shifts LSB first; td_i enters the MSB.
  - Update-IR copies the shift reg to IR.
- Opcode decode:
  - All-ones selects BYPASS.
  - 1 selects IDCODE.
  - CFG_IR_BASE..CFG_IR_BASE+NUM_CFG-1 select config reg k.
  - EXT_IR selects ext.
  - Any other opcode selects BYPASS.
- DR path, per selected register:
  - BYPASS: 1-bit, captures 0.
  - IDCODE: 32-bit, captures IDCODE_VAL.
  - CFG k: CFG_W shift reg, captures synchronised soc_status word k.
  - Shift-DR shifts LSB out first; td_i enters the MSB.
  - One shared CFG_W shift reg serves all config regs.
- Update-DR on CFG k: cfg_o word k <= shift reg on the posedge leaving Update-DR. cfg_upd_o[k]=1 for exactly that one cycle; other words are unchanged.
- EXT: no internal DR. td_o source is ext_scan_out_i. ext_* decodes are asserted combinationally while in the matching state and ext_sel_o=1.
- td_o: on negedge tck_i, td_o <= LSB of the active IR/DR shift reg (or ext_scan_out_i) when in a Shift state; otherwise td_o holds its value and td_oe_o=0.
- Synchroniser: SYNC_STAGES flops per bit on tck_i. Capture uses the last stage, so latency is SYNC_STAGES tck cycles. Multi-bit coherence is the SoC's responsibility (quasi-static).
- Boundary conditions:
  - IR change mid-session does not alter cfg_o.
  - Exit1-DR to Update-DR with zero shifts rewrites the captured status into cfg_o. This is intended.
  - trst_ni asserted mid-shift aborts the shift with no update; cfg_o returns to CFG_RST.
  - Reaching Test-Logic-Reset via tms_i does not clear cfg_o; only trst_ni does.

Test Plan:
- Reset, then 5x tms=1 -> Shift-DR, 32 shifts -> td_o serial equals 32'h10102001 LSB first; td_oe_o=1 only during the shifts.
- Load IR=5'h1F, shift 8 bits 0xA5 -> output lags input by exactly 1 cycle, first bit 0.
- IR=8 (cfg0), shift 9'h1AB, Update-DR -> cfg_o[8:0]=9'h1AB; cfg_upd_o=2'b01 for one cycle; cfg_o[17:9] stays 0.
- soc_status_i word1=9'h0F3 held >=2 cycles; IR=9, Capture/Shift 9 bits -> td_o reads 9'h0F3.
- IR=4 (ext), loop ext_scan_out_i to ext_scan_in_o through a 3-flop chain -> td_o echoes td_i delayed 3 cycles; ext_shift_dr_o high only in Shift-DR.
- Drop trst_ni mid-shift of cfg0 -> cfg_o=0, IR=1, td_oe_o=0 immediately; no cfg_upd_o pulse.
